mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single memory port between the instruction cache and the data cache. Same-cycle grant, fixed-priority or round-robin. Owns a per-tag ownership table so each returned load is steered to the cache that issued it. Sits between the Icache/Dcache controllers and `mem`, replacing the direct Dcache→Dmem connection.

## Interface
- `NUM_TAGS`, default 15: memory transaction tags 1..15; tag 0 means no response or no return.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Icache2arb_command` in 2: `BUS_NONE` / `BUS_LOAD`. `BUS_STORE` from Icache is treated as `BUS_NONE`.
- `Icache2arb_addr` in 64: Icache request address.
- `Dcache2arb_command` in 2: `BUS_NONE` / `BUS_LOAD` / `BUS_STORE`.
- `Dcache2arb_addr` in 64: Dcache request address.
- `Dcache2arb_data` in 64: Dcache store data.
- `mem2arb_response` in 4: tag accepted this cycle; 0 means rejected.
- `mem2arb_data` in 64: returned load data.
- `mem2arb_tag` in 4: tag of returned data; 0 means no return.
- `arb2mem_command` out 2: forwarded command of the grantee.
- `arb2mem_addr` out 64: forwarded address of the grantee.
- `arb2mem_data` out 64: forwarded store data; 0 when Icache is the grantee.
- `arb2Icache_response` out 4: accept tag for Icache; 0 if not granted.
- `arb2Icache_tag` out 4: steered return tag for Icache.
- `arb2Icache_data` out 64: steered return data for Icache.
- `arb2Dcache_response` out 4: accept tag for Dcache; 0 if not granted.
- `arb2Dcache_tag` out 4: steered return tag for Dcache.
- `arb2Dcache_data` out 64: steered return data for Dcache.
- `icache_outstanding` out 4: count of Icache loads in flight.
- `dcache_outstanding` out 4: count of Dcache loads in flight.
- `spurious_return` out 1: sticky flag; set when a return arrives for a tag with no pending entry.

## Operation
Grant is combinational from the current commands and the last-grant register.
- Exactly one requester active: that requester is granted.
- Both active: grant per Configuration.
- Grantee's command, address and data are driven to `arb2mem_*`; otherwise `arb2mem_command = BUS_NONE`, addr = 0, data = 0.
- Grantee receives `mem2arb_response` on its `arb2*_response`. The loser sees 0 and must hold its request and retry.

Ownership table: `NUM_TAGS` entries, each holding `pending` and `owner` (0 = Icache, 1 = Dcache).
- Granted `BUS_LOAD` with nonzero response T: at the clock edge, `pending[T] <= 1` and `owner[T] <= grantee`; the grantee's outstanding counter increments.
- Granted `BUS_STORE`: the response is passed to Dcache; no table entry is created.
- Return with `mem2arb_tag = T != 0` and `pending[T] = 1`: `arb2<owner>_tag = T`, `arb2<owner>_data = mem2arb_data` in the same cycle. The other cache sees tag 0 and data 0. At the edge, `pending[T] <= 0` and the owner's counter decrements.
- Return for a non-pending tag: both steered tags are 0, and `spurious_return <= 1`.
- Same tag T both returning and newly accepted in one cycle: the clear is applied first, then the set, so the entry ends pending with the new owner.
- Same requester both returning and issuing in one cycle: its counter is unchanged.
- Counters saturate at 15 and never go below 0.

## Timing
- Request → response: 0 cycles (combinational through `mem`). The table update is visible from the next cycle.
- A return may arrive no earlier than 1 cycle after acceptance; the data path is combinational from `mem2arb_*`.
- Last-grant register updates only on cycles where both requesters were active and `mem2arb_response != 0`. A rejected grant does not rotate priority.
- Reset values:
  - all `pending` = 0, all `owner` = 0
  - last-grant = Icache, so Dcache wins the first conflict
  - both counters = 0, `spurious_return` = 0
  - all outputs 0 / `BUS_NONE` unless a request is present in that cycle
- Reset mid-operation: the table and counters are cleared. Later returns for pre-reset tags are dropped and set `spurious_return`.

## Configuration
- `MEM_ARB_RR_EN` defined: on conflict, the requester not granted at the last conflict wins (two-way round-robin).
- Undefined: Dcache always wins conflicts; the last-grant register is not implemented. Icache may starve while Dcache requests continuously, and this is acceptable.

## Test plan
- Icache LOAD addr 0x100 alone, mem response 3, later tag 3 with data 0xAAAA → `arb2Icache_response = 3`; the return appears only on the Icache tag/data; `icache_outstanding` goes 1 → 0.
- Simultaneous Icache LOAD 0x200 and Dcache LOAD 0x300, response 5 → Dcache granted (after reset, both builds). The next conflict goes to Icache with RR, and to Dcache without RR.
- Dcache STORE addr 0x28 data 0x1234, response 7 → `arb2mem_data = 0x1234`, `arb2Dcache_response = 7`, `dcache_outstanding` stays 0, and a later tag-7 return sets `spurious_return`.
- Tag 4 returning for Dcache while a new Icache LOAD is accepted with tag 4 → Dcache gets the data; entry 4 is then owned by Icache.
- Two Dcache loads outstanding (tags 1, 2), then reset asserted for one cycle → counters 0; the tag-1 return is steered nowhere and `spurious_return = 1`.
- Mem rejects (response 0) during a conflict → both caches see response 0; the last-grant register is unchanged.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Shared definitions and the bus interface for mem_bus_arbiter.
// The package holds the memory bus command encoding and the requester
// identifier; the interface bundles every cache-side and memory-side
// signal of the arbiter. The arbiter connects through the slave modport,
// the surrounding caches/memory (or a bench) through the master modport.

package mem_bus_arbiter_pkg;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    // Requester identity; the encoding doubles as the stored owner bit
    // (0 = Icache, 1 = Dcache).
    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DCACHE = 1'b1
    } req_e;

endpackage : mem_bus_arbiter_pkg

interface mem_bus_arbiter_if;

    // Cache requests
    logic [1:0]  Icache2arb_command;
    logic [63:0] Icache2arb_addr;
    logic [1:0]  Dcache2arb_command;
    logic [63:0] Dcache2arb_addr;
    logic [63:0] Dcache2arb_data;

    // Memory responses and returns
    logic [3:0]  mem2arb_response;
    logic [63:0] mem2arb_data;
    logic [3:0]  mem2arb_tag;

    // Forwarded request to memory
    logic [1:0]  arb2mem_command;
    logic [63:0] arb2mem_addr;
    logic [63:0] arb2mem_data;

    // Per-cache accept tags and steered returns
    logic [3:0]  arb2Icache_response;
    logic [3:0]  arb2Icache_tag;
    logic [63:0] arb2Icache_data;
    logic [3:0]  arb2Dcache_response;
    logic [3:0]  arb2Dcache_tag;
    logic [63:0] arb2Dcache_data;

    // Arbiter side
    modport slave (
        input  Icache2arb_command, Icache2arb_addr,
        input  Dcache2arb_command, Dcache2arb_addr, Dcache2arb_data,
        input  mem2arb_response, mem2arb_data, mem2arb_tag,
        output arb2mem_command, arb2mem_addr, arb2mem_data,
        output arb2Icache_response, arb2Icache_tag, arb2Icache_data,
        output arb2Dcache_response, arb2Dcache_tag, arb2Dcache_data
    );

    // Cache/memory side
    modport master (
        output Icache2arb_command, Icache2arb_addr,
        output Dcache2arb_command, Dcache2arb_addr, Dcache2arb_data,
        output mem2arb_response, mem2arb_data, mem2arb_tag,
        input  arb2mem_command, arb2mem_addr, arb2mem_data,
        input  arb2Icache_response, arb2Icache_tag, arb2Icache_data,
        input  arb2Dcache_response, arb2Dcache_tag, arb2Dcache_data
    );

endinterface : mem_bus_arbiter_if

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single memory port between the Icache and
// the Dcache with a same-cycle combinational grant, and keeps a per-tag
// ownership table so every returned load is steered to the cache that
// issued it.
//
// Build option: define MEM_ARB_RR_EN to resolve conflicts by two-way
// round-robin (the loser of the last accepted conflict wins the next one).
// Left undefined, the Dcache always wins conflicts and no last-grant
// register exists.

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = 15
) (
    input  logic                clock,
    input  logic                reset,
    mem_bus_arbiter_if.slave    bus,
    output logic [3:0]          icache_outstanding,
    output logic [3:0]          dcache_outstanding,
    output logic                spurious_return
);

    // Highest usable tag, sized to the 4-bit tag fields.
    localparam logic [3:0] MAX_TAG = 4'(NUM_TAGS);

    // Request decode and grant
    logic        w_icache_req;
    logic        w_dcache_req;
    logic        w_conflict;
    logic        w_grant_valid;
    req_e        w_grantee;

    // Forwarded request
    logic [1:0]  w_fwd_cmd;
    logic [63:0] w_fwd_addr;
    logic [63:0] w_fwd_data;

    // Table bookkeeping
    logic        w_load_accept;
    logic        w_ret_hit;
    logic        w_ret_spurious;
    req_e        w_ret_owner;
    logic        w_icache_inc;
    logic        w_icache_dec;
    logic        w_dcache_inc;
    logic        w_dcache_dec;

    // State
    logic [15:0] r_pending;   // bit T set: tag T has a load in flight
    logic [15:0] r_owner;     // bit T: owner of tag T (0 Icache, 1 Dcache)
    logic [3:0]  r_icache_cnt;
    logic [3:0]  r_dcache_cnt;
    logic        r_spurious;

`ifdef MEM_ARB_RR_EN
    req_e        r_last_grant;
`endif

    // Saturating up/down step of an outstanding-load counter; a
    // simultaneous increment and decrement cancel out.
    function automatic logic [3:0] next_count(
        input logic [3:0] cnt,
        input logic       inc,
        input logic       dec
    );
        logic [3:0] result;
        result = cnt;
        if (inc && !dec && (cnt != 4'hF)) begin
            result = cnt + 4'd1;
        end else if (dec && !inc && (cnt != 4'h0)) begin
            result = cnt - 4'd1;
        end
        return result;
    endfunction

    // Decode requests and pick the grantee for this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        w_grantee     = REQ_ICACHE;
        // An Icache STORE is not a legal request and is ignored.
        w_icache_req  = (bus.Icache2arb_command == BUS_LOAD);
        w_dcache_req  = (bus.Dcache2arb_command == BUS_LOAD) ||
                        (bus.Dcache2arb_command == BUS_STORE);
        w_conflict    = w_icache_req && w_dcache_req;
        w_grant_valid = w_icache_req || w_dcache_req;

        if (w_conflict) begin
`ifdef MEM_ARB_RR_EN
            w_grantee = (r_last_grant == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
`else
            w_grantee = REQ_DCACHE;
`endif
        end else if (w_dcache_req) begin
            w_grantee = REQ_DCACHE;
        end
    end

    // Drive the grantee's request to memory and route the accept tag back.
    always_comb begin
        w_fwd_cmd  = BUS_NONE;
        w_fwd_addr = '0;
        w_fwd_data = '0;
        bus.arb2Icache_response = '0;
        bus.arb2Dcache_response = '0;

        if (w_grant_valid) begin
            if (w_grantee == REQ_DCACHE) begin
                w_fwd_cmd  = bus.Dcache2arb_command;
                w_fwd_addr = bus.Dcache2arb_addr;
                w_fwd_data = bus.Dcache2arb_data;
                bus.arb2Dcache_response = bus.mem2arb_response;
            end else begin
                // The Icache only loads, so it never carries store data.
                w_fwd_cmd  = BUS_LOAD;
                w_fwd_addr = bus.Icache2arb_addr;
                bus.arb2Icache_response = bus.mem2arb_response;
            end
        end

        bus.arb2mem_command = w_fwd_cmd;
        bus.arb2mem_addr    = w_fwd_addr;
        bus.arb2mem_data    = w_fwd_data;
    end

    // Classify the accept and the return against the ownership table.
    always_comb begin
        // Only granted loads with a usable tag create a table entry;
        // accepted stores are tracked by nobody.
        w_load_accept  = w_grant_valid && (w_fwd_cmd == BUS_LOAD) &&
                         (bus.mem2arb_response != 4'd0) &&
                         (bus.mem2arb_response <= MAX_TAG);

        // Entry 0 is never set, so tag 0 (no return) can never hit.
        w_ret_hit      = r_pending[bus.mem2arb_tag];
        w_ret_spurious = (bus.mem2arb_tag != 4'd0) && !w_ret_hit;
        w_ret_owner    = req_e'(r_owner[bus.mem2arb_tag]);

        w_icache_inc   = w_load_accept && (w_grantee == REQ_ICACHE);
        w_dcache_inc   = w_load_accept && (w_grantee == REQ_DCACHE);
        w_icache_dec   = w_ret_hit && (w_ret_owner == REQ_ICACHE);
        w_dcache_dec   = w_ret_hit && (w_ret_owner == REQ_DCACHE);
    end

    // Steer a returning load to its owner; the other cache sees zeros.
    always_comb begin
        bus.arb2Icache_tag  = '0;
        bus.arb2Icache_data = '0;
        bus.arb2Dcache_tag  = '0;
        bus.arb2Dcache_data = '0;

        if (w_ret_hit) begin
            if (w_ret_owner == REQ_DCACHE) begin
                bus.arb2Dcache_tag  = bus.mem2arb_tag;
                bus.arb2Dcache_data = bus.mem2arb_data;
            end else begin
                bus.arb2Icache_tag  = bus.mem2arb_tag;
                bus.arb2Icache_data = bus.mem2arb_data;
            end
        end
    end

    // Ownership table: retire the returning tag, then record the new load.
    always_ff @(posedge clock) begin
        // NOTE: the table is ordinary flops, not a RAM, so it is cleared
        // on reset; a returning tag must never match a pre-reset entry.
        if (reset) begin
            r_pending <= '0;
            r_owner   <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state; when the same
            // tag is both retired and re-accepted, the later set below
            // overrides the clear, leaving the entry pending with the new
            // owner.
            if (w_ret_hit) begin
                r_pending[bus.mem2arb_tag] <= 1'b0;
            end
            if (w_load_accept) begin
                r_pending[bus.mem2arb_response] <= 1'b1;
                r_owner[bus.mem2arb_response]   <= w_grantee;
            end
        end
    end

    // Per-cache outstanding-load counters and the sticky spurious flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_icache_cnt <= '0;
            r_dcache_cnt <= '0;
            r_spurious   <= 1'b0;
        end else begin
            r_icache_cnt <= next_count(r_icache_cnt, w_icache_inc, w_icache_dec);
            r_dcache_cnt <= next_count(r_dcache_cnt, w_dcache_inc, w_dcache_dec);
            r_spurious   <= r_spurious | w_ret_spurious;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember the winner of the last accepted conflict; a rejected
    // conflict leaves priority where it was.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= REQ_ICACHE;
        end else if (w_conflict && (bus.mem2arb_response != 4'd0)) begin
            r_last_grant <= w_grantee;
        end
    end
`endif

    assign icache_outstanding = r_icache_cnt;
    assign dcache_outstanding = r_dcache_cnt;
    assign spurious_return    = r_spurious;

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model of
// the arbitration and tag-ownership rules kept in this file.

module tb_mem_bus_arbiter;

    import mem_bus_arbiter_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] icache_outstanding;
    logic [3:0] dcache_outstanding;
    logic       spurious_return;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.NUM_TAGS(15)) dut (
        .clock              (clock),
        .reset              (reset),
        .bus                (bus.slave),
        .icache_outstanding (icache_outstanding),
        .dcache_outstanding (dcache_outstanding),
        .spurious_return    (spurious_return)
    );

    always #5 clock = ~clock;

    // ---------------------------------------------------------------
    // Reference model: tag table as plain arrays, counts as integers.
    // ---------------------------------------------------------------
    bit m_pend  [16];
    bit m_own_d [16];          // 1: tag owned by Dcache
    int m_icnt  = 0;
    int m_dcnt  = 0;
    bit m_spur  = 1'b0;
    bit m_last_d = 1'b0;       // last accepted conflict went to Dcache

    // Inputs applied this cycle
    logic        c_rst;
    logic [1:0]  c_icmd, c_dcmd;
    logic [63:0] c_iaddr, c_daddr, c_ddata, c_rdata;
    logic [3:0]  c_resp, c_rtag;

    // Expectations for this cycle
    bit          e_any, e_win_d, e_hit;
    logic [1:0]  e_cmd;
    logic [63:0] e_addr, e_data, e_idata, e_ddata;
    logic [3:0]  e_iresp, e_dresp, e_itag, e_dtag;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_expect();
        bit ireq, dreq;
        ireq  = (c_icmd == BUS_LOAD);
        dreq  = (c_dcmd == BUS_LOAD) || (c_dcmd == BUS_STORE);
        e_any = ireq || dreq;
`ifdef MEM_ARB_RR_EN
        e_win_d = (ireq && dreq) ? !m_last_d : dreq;
`else
        e_win_d = dreq;
`endif
        e_cmd   = !e_any ? BUS_NONE : (e_win_d ? c_dcmd : BUS_LOAD);
        e_addr  = !e_any ? 64'd0 : (e_win_d ? c_daddr : c_iaddr);
        e_data  = (e_any && e_win_d) ? c_ddata : 64'd0;
        e_iresp = (e_any && !e_win_d) ? c_resp : 4'd0;
        e_dresp = (e_any && e_win_d) ? c_resp : 4'd0;
        e_hit   = (c_rtag != 4'd0) && m_pend[c_rtag];
        e_itag  = (e_hit && !m_own_d[c_rtag]) ? c_rtag : 4'd0;
        e_idata = (e_hit && !m_own_d[c_rtag]) ? c_rdata : 64'd0;
        e_dtag  = (e_hit && m_own_d[c_rtag]) ? c_rtag : 4'd0;
        e_ddata = (e_hit && m_own_d[c_rtag]) ? c_rdata : 64'd0;
    endtask

    task automatic model_update();
        bit load;
        int di, dd;
        if (c_rst) begin
            foreach (m_pend[t]) begin
                m_pend[t]  = 1'b0;
                m_own_d[t] = 1'b0;
            end
            m_icnt = 0; m_dcnt = 0; m_spur = 1'b0; m_last_d = 1'b0;
        end else begin
            load = (e_cmd == BUS_LOAD) && (c_resp != 4'd0);
            di = 0; dd = 0;
            if (load) begin
                if (e_win_d) dd++; else di++;
            end
            if (e_hit) begin
                if (m_own_d[c_rtag]) dd--; else di--;
            end
            m_icnt = (m_icnt + di > 15) ? 15 : ((m_icnt + di < 0) ? 0 : m_icnt + di);
            m_dcnt = (m_dcnt + dd > 15) ? 15 : ((m_dcnt + dd < 0) ? 0 : m_dcnt + dd);
            if (c_rtag != 4'd0 && !e_hit) m_spur = 1'b1;
            if (e_hit) m_pend[c_rtag] = 1'b0;
            if (load) begin
                m_pend[c_resp]  = 1'b1;
                m_own_d[c_resp] = e_win_d;
            end
            if (c_icmd == BUS_LOAD && (c_dcmd == BUS_LOAD || c_dcmd == BUS_STORE)
                && c_resp != 4'd0)
                m_last_d = e_win_d;
        end
    endtask

    task automatic check_all();
        check("mem_cmd",   64'(bus.arb2mem_command),     64'(e_cmd));
        check("mem_addr",  bus.arb2mem_addr,             e_addr);
        check("mem_data",  bus.arb2mem_data,             e_data);
        check("i_resp",    64'(bus.arb2Icache_response), 64'(e_iresp));
        check("d_resp",    64'(bus.arb2Dcache_response), 64'(e_dresp));
        check("i_tag",     64'(bus.arb2Icache_tag),      64'(e_itag));
        check("i_data",    bus.arb2Icache_data,          e_idata);
        check("d_tag",     64'(bus.arb2Dcache_tag),      64'(e_dtag));
        check("d_data",    bus.arb2Dcache_data,          e_ddata);
        check("i_cnt",     64'(icache_outstanding),      64'(m_icnt));
        check("d_cnt",     64'(dcache_outstanding),      64'(m_dcnt));
        check("spurious",  64'(spurious_return),         64'(m_spur));
    endtask

    // Apply one cycle of inputs at the falling edge and compare after settling.
    task automatic drive(input logic rst, input logic [1:0] icmd,
                         input logic [63:0] iaddr, input logic [1:0] dcmd,
                         input logic [63:0] daddr, input logic [63:0] ddata,
                         input logic [3:0] resp, input logic [3:0] rtag,
                         input logic [63:0] rdata);
        @(negedge clock);
        c_rst = rst; c_icmd = icmd; c_iaddr = iaddr; c_dcmd = dcmd;
        c_daddr = daddr; c_ddata = ddata; c_resp = resp; c_rtag = rtag;
        c_rdata = rdata;
        reset                  = rst;
        bus.Icache2arb_command = icmd;
        bus.Icache2arb_addr    = iaddr;
        bus.Dcache2arb_command = dcmd;
        bus.Dcache2arb_addr    = daddr;
        bus.Dcache2arb_data    = ddata;
        bus.mem2arb_response   = resp;
        bus.mem2arb_tag        = rtag;
        bus.mem2arb_data       = rdata;
        #1;
        model_expect();
        check_all();
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
    endtask

    task automatic idle();
        drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd0, 0);
    endtask

    task automatic do_reset();
        drive(1'b1, BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd0, 0);
        tick();
    endtask

    logic [1:0]  r_icmd, r_dcmd;
    logic [3:0]  r_resp, r_rtag;
    logic        r_rst;
    int          p;

    initial begin
        reset = 1'b1;
        bus.Icache2arb_command = BUS_NONE; bus.Icache2arb_addr = '0;
        bus.Dcache2arb_command = BUS_NONE; bus.Dcache2arb_addr = '0;
        bus.Dcache2arb_data = '0; bus.mem2arb_response = '0;
        bus.mem2arb_tag = '0; bus.mem2arb_data = '0;

        // Reset state
        idle();
        check("rst_i_cnt", 64'(icache_outstanding), 64'd0);
        check("rst_spur",  64'(spurious_return), 64'd0);
        check("rst_cmd",   64'(bus.arb2mem_command), 64'(BUS_NONE));
        tick();

        // Lone Icache load, tag 3, later returned
        drive(1'b0, BUS_LOAD, 64'h100, BUS_NONE, 0, 0, 4'd3, 4'd0, 0);
        check("tp1_iresp", 64'(bus.arb2Icache_response), 64'd3);
        check("tp1_addr",  bus.arb2mem_addr, 64'h100);
        tick();
        idle();
        check("tp1_icnt1", 64'(icache_outstanding), 64'd1);
        tick();
        drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd3, 64'hAAAA);
        check("tp1_itag",  64'(bus.arb2Icache_tag), 64'd3);
        check("tp1_idata", bus.arb2Icache_data, 64'hAAAA);
        check("tp1_dtag",  64'(bus.arb2Dcache_tag), 64'd0);
        tick();
        idle();
        check("tp1_icnt0", 64'(icache_outstanding), 64'd0);
        tick();

        // Conflicts: first to Dcache, second per build, reject keeps priority
        do_reset();
        drive(1'b0, BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 0, 4'd5, 4'd0, 0);
        check("tp2_dresp", 64'(bus.arb2Dcache_response), 64'd5);
        check("tp2_iresp", 64'(bus.arb2Icache_response), 64'd0);
        tick();
        drive(1'b0, BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 0, 4'd6, 4'd0, 0);
`ifdef MEM_ARB_RR_EN
        check("tp2_rr_iresp", 64'(bus.arb2Icache_response), 64'd6);
`else
        check("tp2_fp_dresp", 64'(bus.arb2Dcache_response), 64'd6);
`endif
        tick();
        drive(1'b0, BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 0, 4'd0, 4'd0, 0);
        check("tp6_iresp0", 64'(bus.arb2Icache_response), 64'd0);
        check("tp6_dresp0", 64'(bus.arb2Dcache_response), 64'd0);
        tick();
        drive(1'b0, BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 0, 4'd8, 4'd0, 0);
        check("tp6_dresp8", 64'(bus.arb2Dcache_response), 64'd8);
        tick();

        // Dcache store is not tracked; its tag returning is spurious
        do_reset();
        drive(1'b0, BUS_NONE, 0, BUS_STORE, 64'h28, 64'h1234, 4'd7, 4'd0, 0);
        check("tp3_mdata", bus.arb2mem_data, 64'h1234);
        check("tp3_dresp", 64'(bus.arb2Dcache_response), 64'd7);
        tick();
        idle();
        check("tp3_dcnt", 64'(dcache_outstanding), 64'd0);
        tick();
        drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd7, 64'h77);
        check("tp3_dtag", 64'(bus.arb2Dcache_tag), 64'd0);
        tick();
        idle();
        check("tp3_spur", 64'(spurious_return), 64'd1);
        tick();

        // Tag 4 returns to Dcache while re-accepted for Icache
        do_reset();
        drive(1'b0, BUS_NONE, 0, BUS_LOAD, 64'h40, 0, 4'd4, 4'd0, 0);
        tick();
        drive(1'b0, BUS_LOAD, 64'h80, BUS_NONE, 0, 0, 4'd4, 4'd4, 64'h5555);
        check("tp4_dtag",  64'(bus.arb2Dcache_tag), 64'd4);
        check("tp4_ddata", bus.arb2Dcache_data, 64'h5555);
        check("tp4_iresp", 64'(bus.arb2Icache_response), 64'd4);
        tick();
        drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd4, 64'h6666);
        check("tp4_itag", 64'(bus.arb2Icache_tag), 64'd4);
        check("tp4_dtag0", 64'(bus.arb2Dcache_tag), 64'd0);
        tick();

        // Reset drops outstanding Dcache loads
        do_reset();
        drive(1'b0, BUS_NONE, 0, BUS_LOAD, 64'h10, 0, 4'd1, 4'd0, 0); tick();
        drive(1'b0, BUS_NONE, 0, BUS_LOAD, 64'h18, 0, 4'd2, 4'd0, 0); tick();
        idle();
        check("tp5_dcnt2", 64'(dcache_outstanding), 64'd2);
        tick();
        do_reset();
        idle();
        check("tp5_dcnt0", 64'(dcache_outstanding), 64'd0);
        tick();
        drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd1, 64'h11);
        check("tp5_dtag", 64'(bus.arb2Dcache_tag), 64'd0);
        tick();
        idle();
        check("tp5_spur", 64'(spurious_return), 64'd1);
        tick();

        // Counter saturation at 15
        do_reset();
        for (int t = 1; t <= 15; t++) begin
            drive(1'b0, BUS_NONE, 0, BUS_LOAD, 64'(t), 0, 4'(t), 4'd0, 0);
            tick();
        end
        drive(1'b0, BUS_NONE, 0, BUS_LOAD, 64'h99, 0, 4'd1, 4'd0, 0);
        tick();
        idle();
        check("sat_dcnt15", 64'(dcache_outstanding), 64'd15);
        tick();
        for (int t = 1; t <= 15; t++) begin
            drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'(t), 64'(t));
            tick();
        end
        idle();
        check("sat_dcnt0", 64'(dcache_outstanding), 64'd0);
        tick();

        // Randomized traffic with a well-behaved memory
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 3))
                0:       r_icmd = BUS_NONE;
                3:       r_icmd = BUS_STORE;
                default: r_icmd = BUS_LOAD;
            endcase
            case ($urandom_range(0, 3))
                0:       r_dcmd = BUS_NONE;
                2:       r_dcmd = BUS_STORE;
                default: r_dcmd = BUS_LOAD;
            endcase
            r_rtag = 4'd0;
            p = $urandom_range(0, 99);
            if (p < 45) begin
                for (int k = 0; k < 16; k++) begin
                    r_rtag = 4'($urandom_range(1, 15));
                    if (m_pend[r_rtag]) break;
                    r_rtag = 4'd0;
                end
            end else if (p < 47) begin
                r_rtag = 4'($urandom_range(1, 15));
            end
            r_resp = 4'd0;
            if ((r_icmd == BUS_LOAD || r_dcmd != BUS_NONE) &&
                $urandom_range(0, 9) < 8) begin
                if (r_rtag != 4'd0 && m_pend[r_rtag] && $urandom_range(0, 3) == 0) begin
                    r_resp = r_rtag;
                end else begin
                    for (int k = 0; k < 16; k++) begin
                        r_resp = 4'($urandom_range(1, 15));
                        if (!m_pend[r_resp]) break;
                        r_resp = 4'd0;
                    end
                end
            end
            drive(r_rst, r_icmd, {$urandom, $urandom}, r_dcmd,
                  {$urandom, $urandom}, {$urandom, $urandom},
                  r_resp, r_rtag, {$urandom, $urandom});
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_bus_arbiter
